// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg
// Shared types and constants for the cache-side memory initiator.
//   state_t    : FSM states of cache_mem_master
//   req_kind_t : which cache-side request is currently being served
//   BEATS, BEAT_BITS, LINE_OFFSET_BITS, WORD_OFFSET_BITS : line geometry
package cache_mem_pkg;

  localparam int BEATS            = 4;
  localparam int BEAT_BITS        = 2;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int WORD_OFFSET_BITS = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_BEAT,
    WR_WAIT
  } state_t;

  typedef enum logic [1:0] {
    REQ_WB,
    REQ_REFILL,
    REQ_ST
  } req_kind_t;

endpackage

// File: rtl/cache_mem_master.sv
// cache_mem_master
// Serialises line refills (one 256-bit read), dirty-line write-backs (four
// full-strobe 64-bit writes) and write-through stores (one strobed write)
// onto the main-memory read/write channels. Only one memory access is in
// flight at a time, so a read request and a write valid never coincide.
// Ports:
//   i_clk, i_rst_n                     clock, async active-low reset
//   i_refill_req/addr, o_refill_done/line   line refill request / result
//   i_wb_req/addr/line, o_wb_done            dirty-line write-back
//   i_st_req/addr/data/strb, o_st_done       write-through store
//   o_busy                                   FSM not in IDLE
//   o_mem_read_req/address, i_mem_read_done, i_cache_line   memory read
//   o_mem_write_valid/address/data, o_write_strobe, i_mem_write_done
module cache_mem_master
  import cache_mem_pkg::*;
#(
  parameter int ADDR_WIDTH       = 64,
  parameter int DATA_WIDTH       = 64,
  parameter int CACHE_LINE_WIDTH = 256
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_refill_req,
  input  logic [ADDR_WIDTH-1:0]       i_refill_addr,
  output logic                        o_refill_done,
  output logic [CACHE_LINE_WIDTH-1:0] o_refill_line,
  input  logic                        i_wb_req,
  input  logic [ADDR_WIDTH-1:0]       i_wb_addr,
  input  logic [CACHE_LINE_WIDTH-1:0] i_wb_line,
  output logic                        o_wb_done,
  input  logic                        i_st_req,
  input  logic [ADDR_WIDTH-1:0]       i_st_addr,
  input  logic [DATA_WIDTH-1:0]       i_st_data,
  input  logic [7:0]                  i_st_strb,
  output logic                        o_st_done,
  output logic                        o_busy,
  output logic                        o_mem_read_req,
  output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
  input  logic                        i_mem_read_done,
  input  logic [CACHE_LINE_WIDTH-1:0] i_cache_line,
  output logic                        o_mem_write_valid,
  output logic [ADDR_WIDTH-1:0]       o_mem_write_address,
  output logic [DATA_WIDTH-1:0]       o_mem_write_data,
  output logic [7:0]                  o_write_strobe,
  input  logic                        i_mem_write_done
);

  localparam int TAG_W = ADDR_WIDTH - LINE_OFFSET_BITS;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

  state_t                      state_reg, state_next;
  req_kind_t                   kind_reg, kind_next;
  logic [BEAT_BITS-1:0]        beat_reg, beat_next, beat_inc;
  logic [TAG_W-1:0]            line_addr_reg, line_addr_next;
  logic [CACHE_LINE_WIDTH-1:0] wb_line_reg, wb_line_next;

  logic                        rd_req_next, wr_valid_next;
  logic [ADDR_WIDTH-1:0]       rd_addr_next, wr_addr_next;
  logic [DATA_WIDTH-1:0]       wr_data_next;
  logic [7:0]                  wr_strb_next;
  logic [CACHE_LINE_WIDTH-1:0] refill_line_next;
  logic                        refill_done_next, wb_done_next, st_done_next;

  // Sub-line offset bits are discarded by the alignment rules.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_refill_addr[LINE_OFFSET_BITS-1:0],
                              i_wb_addr[LINE_OFFSET_BITS-1:0],
                              i_st_addr[WORD_OFFSET_BITS-1:0]};

  // Captured dirty line viewed as an array of write beats.
  logic [DATA_WIDTH-1:0] wb_beat [BEATS];
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      assign wb_beat[gi] = wb_line_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign beat_inc = beat_reg + BEAT_BITS'(1);

  always_comb begin
    state_next       = state_reg;
    kind_next        = kind_reg;
    beat_next        = beat_reg;
    line_addr_next   = line_addr_reg;
    wb_line_next     = wb_line_reg;
    rd_req_next      = 1'b0;
    rd_addr_next     = o_mem_read_address;
    wr_valid_next    = 1'b0;
    wr_addr_next     = o_mem_write_address;
    wr_data_next     = o_mem_write_data;
    wr_strb_next     = o_write_strobe;
    refill_line_next = o_refill_line;
    refill_done_next = 1'b0;
    wb_done_next     = 1'b0;
    st_done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        // Write-back wins so a victim leaves before its replacement arrives.
        if (i_wb_req) begin
          kind_next      = REQ_WB;
          beat_next      = '0;
          line_addr_next = i_wb_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS];
          wb_line_next   = i_wb_line;
          wr_valid_next  = 1'b1;
          wr_addr_next   = {i_wb_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS],
                            {LINE_OFFSET_BITS{1'b0}}};
          wr_data_next   = i_wb_line[DATA_WIDTH-1:0];
          wr_strb_next   = 8'hFF;
          state_next     = WR_BEAT;
        end else if (i_refill_req) begin
          kind_next    = REQ_REFILL;
          rd_req_next  = 1'b1;
          rd_addr_next = {i_refill_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS],
                          {LINE_OFFSET_BITS{1'b0}}};
          state_next   = RD_REQ;
        end else if (i_st_req) begin
          if (i_st_strb == 8'h00) begin
            // Nothing to write: acknowledge without touching memory.
            st_done_next = 1'b1;
          end else begin
            kind_next     = REQ_ST;
            wr_valid_next = 1'b1;
            wr_addr_next  = {i_st_addr[ADDR_WIDTH-1:WORD_OFFSET_BITS],
                             {WORD_OFFSET_BITS{1'b0}}};
            wr_data_next  = i_st_data;
            wr_strb_next  = i_st_strb;
            state_next    = WR_BEAT;
          end
        end
      end
      RD_REQ: state_next = RD_WAIT;
      RD_WAIT: begin
        if (i_mem_read_done) begin
          refill_line_next = i_cache_line;
          refill_done_next = 1'b1;
          state_next       = IDLE;
        end
      end
      WR_BEAT: state_next = WR_WAIT;
      WR_WAIT: begin
        if (i_mem_write_done) begin
          if (kind_reg == REQ_WB && beat_reg != LAST_BEAT) begin
            beat_next     = beat_inc;
            wr_valid_next = 1'b1;
            wr_addr_next  = {line_addr_reg, beat_inc, {WORD_OFFSET_BITS{1'b0}}};
            wr_data_next  = wb_beat[beat_inc];
            state_next    = WR_BEAT;
          end else begin
            wb_done_next = (kind_reg == REQ_WB);
            st_done_next = (kind_reg != REQ_WB);
            state_next   = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg           <= IDLE;
      kind_reg            <= REQ_WB;
      beat_reg            <= '0;
      line_addr_reg       <= '0;
      wb_line_reg         <= '0;
      o_busy              <= 1'b0;
      o_mem_read_req      <= 1'b0;
      o_mem_read_address  <= '0;
      o_mem_write_valid   <= 1'b0;
      o_mem_write_address <= '0;
      o_mem_write_data    <= '0;
      o_write_strobe      <= '0;
      o_refill_line       <= '0;
      o_refill_done       <= 1'b0;
      o_wb_done           <= 1'b0;
      o_st_done           <= 1'b0;
    end else begin
      state_reg           <= state_next;
      kind_reg            <= kind_next;
      beat_reg            <= beat_next;
      line_addr_reg       <= line_addr_next;
      wb_line_reg         <= wb_line_next;
      o_busy              <= (state_next != IDLE);
      o_mem_read_req      <= rd_req_next;
      o_mem_read_address  <= rd_addr_next;
      o_mem_write_valid   <= wr_valid_next;
      o_mem_write_address <= wr_addr_next;
      o_mem_write_data    <= wr_data_next;
      o_write_strobe      <= wr_strb_next;
      o_refill_line       <= refill_line_next;
      o_refill_done       <= refill_done_next;
      o_wb_done           <= wb_done_next;
      o_st_done           <= st_done_next;
    end
  end

endmodule

// File: doc/cache_mem_master.md
# cache_mem_master

Cache-side initiator for the main-memory read/write channels. It serialises three cache-side request kinds onto the memory interface:
- **Line refill:** one 256-bit read.
- **Dirty-line write-back:** four 64-bit full-strobe writes.
- **Write-through store:** one strobed 64-bit write.

It sits between the L1 data-cache controller and main memory, and guarantees the memory never sees a read request and a write valid in the same cycle.

## Interface
- ADDR_WIDTH, 64, byte-address width
- DATA_WIDTH, 64, memory write beat width
- CACHE_LINE_WIDTH, 256, line width; BEATS = CACHE_LINE_WIDTH/DATA_WIDTH = 4
- i_clk  in  1  clock; one clock domain
- i_rst_n  in  1  reset, asynchronous, active-low
- i_refill_req  in  1  refill request, level, held until o_refill_done
- i_refill_addr  in  ADDR_WIDTH  any byte in the line
- o_refill_done  out  1  one-cycle pulse
- o_refill_line  out  CACHE_LINE_WIDTH  line data, valid with o_refill_done, held until next refill
- i_wb_req  in  1  write-back request, level, held until o_wb_done
- i_wb_addr  in  ADDR_WIDTH  line address
- i_wb_line  in  CACHE_LINE_WIDTH  dirty line
- o_wb_done  out  1  one-cycle pulse
- i_st_req  in  1  store request, level, held until o_st_done
- i_st_addr  in  ADDR_WIDTH  store address
- i_st_data  in  DATA_WIDTH  store data, dword-lane aligned
- i_st_strb  in  8  byte strobes
- o_st_done  out  1  one-cycle pulse
- o_busy  out  1  high whenever the state is not IDLE
- o_mem_read_req  out  1  memory read request
- o_mem_read_address  out  ADDR_WIDTH  memory read address
- i_mem_read_done  in  1  memory read completion
- i_cache_line  in  CACHE_LINE_WIDTH  line returned by memory
- o_mem_write_valid  out  1  memory write valid
- o_mem_write_address  out  ADDR_WIDTH  memory write address
- o_mem_write_data  out  DATA_WIDTH  memory write data
- o_write_strobe  out  8  memory write byte strobes
- i_mem_write_done  in  1  memory write completion

## Operation
- **Reset values:** every output is 0, including o_refill_line. State is IDLE and the beat counter is 0.
- **FSM states:** IDLE, RD_REQ, RD_WAIT, WR_BEAT, WR_WAIT.
- **IDLE arbitration:** fixed priority wb > refill > st, so a victim is written back before its replacement is fetched. On acceptance, the address, data and strobes are captured into registers. Inputs are not sampled again until the next IDLE.
- **Refill:**
  - IDLE → RD_REQ: o_mem_read_req = 1 for exactly one cycle, o_mem_read_address = {addr[ADDR_WIDTH-1:5], 5'b0}.
  - → RD_WAIT.
  - On i_mem_read_done: register i_cache_line into o_refill_line, pulse o_refill_done, → IDLE.
- **Write-back:**
  - Beat counter k runs 0..3.
  - WR_BEAT: o_mem_write_valid = 1 for one cycle, address = {addr[ADDR_WIDTH-1:5], k[1:0], 3'b0}, data = line[64k+63:64k], strobe = 8'hFF.
  - → WR_WAIT.
  - On i_mem_write_done: if k < 3, increment k and → WR_BEAT; if k = 3, pulse o_wb_done and → IDLE.
- **Store:**
  - Single WR_BEAT, address = {addr[ADDR_WIDTH-1:3], 3'b0}, strobe = i_st_strb.
  - Pulse o_st_done on i_mem_write_done.
  - If i_st_strb == 0, pulse o_st_done in the cycle after acceptance with no memory access, and stay in IDLE.
- **Request drop rule:** the requester drops req in the done-pulse cycle. A req still high in the following cycle is treated as a new request.
- **Spurious completions:** i_mem_read_done or i_mem_write_done arriving in IDLE, or in a state not expecting it, is ignored.
- **Reset mid-operation:** the operation is aborted immediately. No done pulse is issued for it, and a later stale memory done is ignored.

## Timing
- All outputs are registered. Request edge E0 is the edge at which IDLE samples the request.
- **Refill:** o_mem_read_req is high in cycle E0+1 and memory done arrives in E0+2. o_refill_done is high in E0+3, so latency is 3 cycles.
- **Write-back:** 2 cycles per beat. Valids are in cycles E0+1, +3, +5, +7; o_wb_done is in E0+9.
- **Store:** o_mem_write_valid is in E0+1 and o_st_done is in E0+3. With a zero strobe, o_st_done is in E0+1.
- o_mem_read_req and o_mem_write_valid are never high together and are never high in consecutive cycles.
- **Back-to-back:** a new request is accepted at the edge ending the done cycle at the earliest.

## Structure
- Package cache_mem_pkg holds:
  - the state enum typedef;
  - BEATS, LINE_OFFSET_BITS = 5, WORD_OFFSET_BITS = 3;
  - the request-kind enum {REQ_WB, REQ_REFILL, REQ_ST}.
- Single module with no sub-module. The arbiter, FSM, beat counter and capture registers are all in one block.

## Test plan
- **Refill:** memory preloaded with dwords 0x11, 0x22, 0x33, 0x44 at 0x1220..0x1238; refill of 0x1234 → read address 0x1220 for one cycle, o_refill_done at E0+3, o_refill_line = {0x44, 0x33, 0x22, 0x11}.
- **Write-back:** line {D3, D2, D1, D0} to 0x2040 → writes at 0x2040, 0x2048, 0x2050, 0x2058 with D0..D3 and strobe 0xFF, o_wb_done at E0+9; a subsequent refill returns the same line.
- **Store:** 0x3005, data 0xAABBCCDD_EEFF0011, strobe 0x0F over memory 0 → write address 0x3000, strobe 0x0F, readback 0x00000000_EEFF0011. A strobe of 0 → o_st_done at E0+1 with no o_mem_write_valid.
- **Simultaneous requests:** wb, refill and st raised in the same cycle → order is wb, then refill (returns the written-back data), then st. Exactly one done pulse per request, and read/write are never concurrent.
- **Reset mid write-back:** assert i_rst_n low after beat 1 → all outputs 0 and no o_wb_done. A stale i_mem_write_done is injected in IDLE and ignored; the next refill completes in 3 cycles.
